toy_mem_copy_dma: RTL

//  Bus initiator for the toy single-port SRAM-style memory interface (en/addr/wr_en/wr_byte_en/wr_data/rd_data).
//  The memory side (toy_mem_model, toy_env_slv) is the responder. This block drives that interface to copy a

---
 rtl/toy_mem_copy_dma_pkg.sv | 11 +
 rtl/toy_mem_copy_dma.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/toy_mem_copy_dma_pkg.sv
// Shared widths and state encoding for the toy memory copy/fill DMA initiator.
package toy_mem_copy_dma_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int DMA_LEN_WIDTH  = 16;
  localparam int DMA_WORD_BYTES = BUS_DATA_WIDTH / 8;

  typedef enum logic [2:0] {DMA_IDLE, DMA_RD, DMA_LAT, DMA_WR, DMA_FIN} dma_state_t;

endpackage

// File: rtl/toy_mem_copy_dma.sv
// Bus initiator that copies a word block src->dst or fills a block with a pattern
// over the toy single-port SRAM interface; all memory-side outputs are registered.
module toy_mem_copy_dma
  import toy_mem_copy_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int LEN_WIDTH  = DMA_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_vld,
  output logic                    cfg_rdy,
  input  logic                    cfg_fill,
  input  logic [ADDR_WIDTH-1:0]   cfg_src,
  input  logic [ADDR_WIDTH-1:0]   cfg_dst,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [DATA_WIDTH-1:0]   cfg_pattern,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wr_en,
  output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1));
  localparam logic [LEN_WIDTH-1:0]  ONE        = LEN_WIDTH'(1);

  dma_state_t            state;
  logic                  fill;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] pattern;
  logic [ADDR_WIDTH-1:0] src_al;
  logic [ADDR_WIDTH-1:0] dst_al;

  assign src_al  = cfg_src & ALIGN_MASK;
  assign dst_al  = cfg_dst & ALIGN_MASK;
  assign cfg_rdy = (state == DMA_IDLE);
  assign busy    = (state != DMA_IDLE);

  // Outputs are set on the edge that enters a state, so each bus cycle is visible
  // during the state that names it; pointers advance as each access is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= DMA_IDLE;
      fill           <= 1'b0;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      remaining      <= '0;
      pattern        <= '0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      mem_en         <= 1'b0;
      mem_addr       <= '0;
      mem_wr_en      <= 1'b0;
      mem_wr_byte_en <= '0;
      mem_wr_data    <= '0;
    end else begin
      done           <= 1'b0;
      aborted        <= 1'b0;
      mem_en         <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_wr_byte_en <= '0;
      case (state)
        DMA_IDLE: begin
          if (cfg_vld) begin
            fill    <= cfg_fill;
            pattern <= cfg_pattern;
            if (cfg_len == '0) begin
              state <= DMA_FIN;
            end else if (cfg_fill) begin
              state          <= DMA_WR;
              mem_en         <= 1'b1;
              mem_wr_en      <= 1'b1;
              mem_wr_byte_en <= '1;
              mem_addr       <= dst_al;
              mem_wr_data    <= cfg_pattern;
              dst_ptr        <= dst_al + STEP;
              remaining      <= cfg_len - ONE;
            end else begin
              state     <= DMA_RD;
              mem_en    <= 1'b1;
              mem_addr  <= src_al;
              src_ptr   <= src_al + STEP;
              dst_ptr   <= dst_al;
              remaining <= cfg_len;
            end
          end
        end
        DMA_RD: begin
          if (abort) begin
            state   <= DMA_FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            state <= DMA_LAT;
          end
        end
        DMA_LAT: begin
          if (abort) begin
            state   <= DMA_FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            state          <= DMA_WR;
            mem_en         <= 1'b1;
            mem_wr_en      <= 1'b1;
            mem_wr_byte_en <= '1;
            mem_addr       <= dst_ptr;
            mem_wr_data    <= mem_rd_data;
            dst_ptr        <= dst_ptr + STEP;
            remaining      <= remaining - ONE;
          end
        end
        DMA_WR: begin
          if (abort || remaining == '0) begin
            state   <= DMA_FIN;
            done    <= 1'b1;
            aborted <= abort;
          end else if (fill) begin
            mem_en         <= 1'b1;
            mem_wr_en      <= 1'b1;
            mem_wr_byte_en <= '1;
            mem_addr       <= dst_ptr;
            mem_wr_data    <= pattern;
            dst_ptr        <= dst_ptr + STEP;
            remaining      <= remaining - ONE;
          end else begin
            state    <= DMA_RD;
            mem_en   <= 1'b1;
            mem_addr <= src_ptr;
            src_ptr  <= src_ptr + STEP;
          end
        end
        DMA_FIN: begin
          // A zero-length command arrives with done low and spends one extra cycle here.
          if (done) begin
            state <= DMA_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= DMA_IDLE;
      endcase
    end
  end

endmodule
